pio_pin_latch: RTL and testbench

- Per-FSM pin state holder; one instance per state machine (4 cores x 4 FSMs).
- Receives pin and pindir write events from the FSM execute stage (OUT, SET, side-set) and from a host debug port.
- Applies each event to a sticky 32-bit output latch and a sticky 32-bit drive (pindir) latch, using base/count windows that wrap modulo NUM_PINS.
- Its registered outputs feed the downstream output arbitrator's fsm_output/fsm_drive inputs for its slot.

---
 rtl/pio_pin_latch_pkg.sv | 40 ++++
 rtl/pio_pin_latch_if.sv | 48 ++++
 rtl/pio_pin_latch_window.sv | 34 +++
 rtl/pio_pin_latch.sv | 109 ++++++++++
 tb/tb_pio_pin_latch.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/pio_pin_latch_pkg.sv
// Shared constants for the per-FSM pin latch: pin count, window limits,
// counter widths and the order in which write sources are layered.
package pio_pin_latch_pkg;

  localparam int NUM_PINS      = 32;
  localparam int SET_MAX       = 5;
  localparam int SIDESET_MAX   = 5;
  localparam int PIN_W         = $clog2(NUM_PINS);
  localparam int OUT_CNT_W     = 6;
  localparam int SET_CNT_W     = 3;
  localparam int SIDESET_CNT_W = 3;
  localparam int SET_DATA_W    = 5;
  localparam int SIDESET_DATA_W = 5;

  // Write sources for one latch.
  typedef enum logic [1:0] {
    SRC_HOST    = 2'd0,
    SRC_OUT     = 2'd1,
    SRC_SET     = 2'd2,
    SRC_SIDESET = 2'd3
  } src_e;

  localparam int NUM_SRC = 4;

  // Sources are applied in this order, so a later entry overwrites an
  // earlier one on overlapping pins: side-set > SET > OUT > host.
  localparam src_e PRIO_LOW_TO_HIGH [NUM_SRC] =
    '{SRC_HOST, SRC_OUT, SRC_SET, SRC_SIDESET};

  // Rotate a pin vector left, so bit i lands on pin (i + sh) mod NUM_PINS.
  function automatic logic [NUM_PINS-1:0] rotl_pins(
    input logic [NUM_PINS-1:0] x,
    input logic [PIN_W-1:0]    sh
  );
    logic [2*NUM_PINS-1:0] dbl;
    dbl = {x, x} << sh;
    return dbl[2*NUM_PINS-1:NUM_PINS];
  endfunction

endpackage

// File: rtl/pio_pin_latch_if.sv
// Event and result bundle between the FSM execute stage / host debug port
// (master) and the pin latch (slave).
interface pio_pin_latch_if;
  import pio_pin_latch_pkg::*;

  logic                      fsm_enable;
  logic [PIN_W-1:0]          out_base;
  logic [PIN_W-1:0]          set_base;
  logic [PIN_W-1:0]          sideset_base;
  logic                      sideset_pindirs;
  logic                      out_valid;
  logic                      out_to_dirs;
  logic [NUM_PINS-1:0]       out_data;
  logic [OUT_CNT_W-1:0]      out_count;
  logic                      set_valid;
  logic                      set_to_dirs;
  logic [SET_DATA_W-1:0]     set_data;
  logic [SET_CNT_W-1:0]      set_count;
  logic                      sideset_valid;
  logic [SIDESET_DATA_W-1:0] sideset_data;
  logic [SIDESET_CNT_W-1:0]  sideset_count;
  logic                      host_we_pins;
  logic                      host_we_dirs;
  logic [NUM_PINS-1:0]       host_mask;
  logic [NUM_PINS-1:0]       host_data;
  logic [NUM_PINS-1:0]       fsm_output;
  logic [NUM_PINS-1:0]       fsm_drive;
  logic                      write_conflict;

  modport master (
    output fsm_enable, out_base, set_base, sideset_base, sideset_pindirs,
           out_valid, out_to_dirs, out_data, out_count,
           set_valid, set_to_dirs, set_data, set_count,
           sideset_valid, sideset_data, sideset_count,
           host_we_pins, host_we_dirs, host_mask, host_data,
    input  fsm_output, fsm_drive, write_conflict
  );

  modport slave (
    input  fsm_enable, out_base, set_base, sideset_base, sideset_pindirs,
           out_valid, out_to_dirs, out_data, out_count,
           set_valid, set_to_dirs, set_data, set_count,
           sideset_valid, sideset_data, sideset_count,
           host_we_pins, host_we_dirs, host_mask, host_data,
    output fsm_output, fsm_drive, write_conflict
  );

endinterface

// File: rtl/pio_pin_latch_window.sv
// Combinational pin window: turns (base, count, data) into a pin mask and
// pin-aligned data, clamping count and wrapping pins modulo NUM_PINS.
module pio_pin_window
  import pio_pin_latch_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 6,
  parameter int MAX_CNT = 32
) (
  input  logic [PIN_W-1:0]    base,
  input  logic [CNT_W-1:0]    count,
  input  logic [DATA_W-1:0]   data,
  output logic [NUM_PINS-1:0] mask,
  output logic [NUM_PINS-1:0] data_rot
);

  int                  cnt_clamped;
  logic [NUM_PINS-1:0] mask_lin;
  logic [NUM_PINS-1:0] data_lin;

  // Clamp the count, build the unrotated mask/data, then rotate onto pins.
  always_comb begin
    cnt_clamped = (int'(count) > MAX_CNT) ? MAX_CNT : int'(count);
    mask_lin    = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      mask_lin[i] = (i < cnt_clamped);
    end
    data_lin             = '0;
    data_lin[DATA_W-1:0] = data;
    mask                 = rotl_pins(mask_lin, base);
    data_rot             = rotl_pins(data_lin & mask_lin, base);
  end

endmodule

// File: rtl/pio_pin_latch.sv
// Per-FSM sticky pin output and pin direction latches. OUT, SET, side-set
// and host writes are windowed, layered by priority per latch, and
// registered for the output arbitrator.
module pio_pin_latch
  import pio_pin_latch_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  pio_pin_latch_if.slave bus
);

  logic out_vld, set_vld, sideset_vld;

  logic [NUM_PINS-1:0] out_mask, out_rot;
  logic [NUM_PINS-1:0] set_mask, set_rot;
  logic [NUM_PINS-1:0] sideset_mask, sideset_rot;

  // Per-source masks and data, one set per latch, indexed by src_e.
  logic [NUM_PINS-1:0] pins_mask [NUM_SRC];
  logic [NUM_PINS-1:0] pins_data [NUM_SRC];
  logic [NUM_PINS-1:0] dirs_mask [NUM_SRC];
  logic [NUM_PINS-1:0] dirs_data [NUM_SRC];

  logic [NUM_PINS-1:0] output_nxt, drive_nxt;
  logic [NUM_PINS-1:0] output_p0, drive_p0;
  logic                conflict_p0;

  assign out_vld     = bus.out_valid     & bus.fsm_enable;
  assign set_vld     = bus.set_valid     & bus.fsm_enable;
  assign sideset_vld = bus.sideset_valid & bus.fsm_enable;

  pio_pin_window #(.DATA_W(NUM_PINS), .CNT_W(OUT_CNT_W), .MAX_CNT(NUM_PINS)) u_out_win (
    .base     (bus.out_base),
    .count    (bus.out_count),
    .data     (bus.out_data),
    .mask     (out_mask),
    .data_rot (out_rot)
  );

  pio_pin_window #(.DATA_W(SET_DATA_W), .CNT_W(SET_CNT_W), .MAX_CNT(SET_MAX)) u_set_win (
    .base     (bus.set_base),
    .count    (bus.set_count),
    .data     (bus.set_data),
    .mask     (set_mask),
    .data_rot (set_rot)
  );

  pio_pin_window #(.DATA_W(SIDESET_DATA_W), .CNT_W(SIDESET_CNT_W), .MAX_CNT(SIDESET_MAX)) u_sideset_win (
    .base     (bus.sideset_base),
    .count    (bus.sideset_count),
    .data     (bus.sideset_data),
    .mask     (sideset_mask),
    .data_rot (sideset_rot)
  );

  // Route each source to the latch its select points at; idle sources get an empty mask.
  always_comb begin
    pins_mask[SRC_HOST]    = bus.host_we_pins ? bus.host_mask : '0;
    pins_data[SRC_HOST]    = bus.host_data;
    dirs_mask[SRC_HOST]    = bus.host_we_dirs ? bus.host_mask : '0;
    dirs_data[SRC_HOST]    = bus.host_data;

    pins_mask[SRC_OUT]     = (out_vld && !bus.out_to_dirs) ? out_mask : '0;
    pins_data[SRC_OUT]     = out_rot;
    dirs_mask[SRC_OUT]     = (out_vld &&  bus.out_to_dirs) ? out_mask : '0;
    dirs_data[SRC_OUT]     = out_rot;

    pins_mask[SRC_SET]     = (set_vld && !bus.set_to_dirs) ? set_mask : '0;
    pins_data[SRC_SET]     = set_rot;
    dirs_mask[SRC_SET]     = (set_vld &&  bus.set_to_dirs) ? set_mask : '0;
    dirs_data[SRC_SET]     = set_rot;

    pins_mask[SRC_SIDESET] = (sideset_vld && !bus.sideset_pindirs) ? sideset_mask : '0;
    pins_data[SRC_SIDESET] = sideset_rot;
    dirs_mask[SRC_SIDESET] = (sideset_vld &&  bus.sideset_pindirs) ? sideset_mask : '0;
    dirs_data[SRC_SIDESET] = sideset_rot;
  end

  // Layer sources lowest priority first so higher ones overwrite shared pins.
  always_comb begin
    output_nxt = output_p0;
    drive_nxt  = drive_p0;
    for (int k = 0; k < NUM_SRC; k++) begin
      output_nxt = (output_nxt & ~pins_mask[PRIO_LOW_TO_HIGH[k]])
                 | (pins_data[PRIO_LOW_TO_HIGH[k]] & pins_mask[PRIO_LOW_TO_HIGH[k]]);
      drive_nxt  = (drive_nxt & ~dirs_mask[PRIO_LOW_TO_HIGH[k]])
                 | (dirs_data[PRIO_LOW_TO_HIGH[k]] & dirs_mask[PRIO_LOW_TO_HIGH[k]]);
    end
  end

  // ---- stage p0: registered latches and conflict pulse ----
  // Hold latch state; reset discards any event presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      output_p0   <= '0;
      drive_p0    <= '0;
      conflict_p0 <= 1'b0;
    end else begin
      output_p0   <= output_nxt;
      drive_p0    <= drive_nxt;
      conflict_p0 <= out_vld & set_vld;
    end
  end

  assign bus.fsm_output     = output_p0;
  assign bus.fsm_drive      = drive_p0;
  assign bus.write_conflict = conflict_p0;

endmodule

// File: tb/tb_pio_pin_latch.sv
// Directed bench for pio_pin_latch: hand-computed latch values after each event.
module tb_pio_pin_latch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pio_pin_latch_if bus ();

  pio_pin_latch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.fsm_enable      = 1'b1;
    bus.out_base        = '0;
    bus.set_base        = '0;
    bus.sideset_base    = '0;
    bus.sideset_pindirs = 1'b0;
    bus.out_valid       = 1'b0;
    bus.out_to_dirs     = 1'b0;
    bus.out_data        = '0;
    bus.out_count       = '0;
    bus.set_valid       = 1'b0;
    bus.set_to_dirs     = 1'b0;
    bus.set_data        = '0;
    bus.set_count       = '0;
    bus.sideset_valid   = 1'b0;
    bus.sideset_data    = '0;
    bus.sideset_count   = '0;
    bus.host_we_pins    = 1'b0;
    bus.host_we_dirs    = 1'b0;
    bus.host_mask       = '0;
    bus.host_data       = '0;
  endtask

  task automatic randomize_inputs();
    bus.fsm_enable      = 1'b1;
    bus.out_base        = 5'($urandom);
    bus.set_base        = 5'($urandom);
    bus.sideset_base    = 5'($urandom);
    bus.sideset_pindirs = 1'($urandom);
    bus.out_valid       = 1'b1;
    bus.out_to_dirs     = 1'($urandom);
    bus.out_data        = $urandom | 32'h1;
    bus.out_count       = 6'd32;
    bus.set_valid       = 1'b1;
    bus.set_to_dirs     = 1'($urandom);
    bus.set_data        = 5'h1F;
    bus.set_count       = 3'd5;
    bus.sideset_valid   = 1'b1;
    bus.sideset_data    = 5'h1F;
    bus.sideset_count   = 3'd5;
    bus.host_we_pins    = 1'b1;
    bus.host_we_dirs    = 1'b1;
    bus.host_mask       = 32'hFFFFFFFF;
    bus.host_data       = 32'hFFFFFFFF;
  endtask

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    randomize_inputs();
    #1;

    // Reset with live events held: nothing gets through.
    step();
    chk("rst_out", bus.fsm_output, 32'h0);
    randomize_inputs();
    step();
    chk("rst_drive", bus.fsm_drive, 32'h0);
    chk("rst_conflict", {31'b0, bus.write_conflict}, 32'h0);
    rst = 1'b0;
    idle();
    step();
    chk("post_rst_out", bus.fsm_output, 32'h0);
    chk("post_rst_drive", bus.fsm_drive, 32'h0);
    chk("post_rst_conflict", {31'b0, bus.write_conflict}, 32'h0);

    // Host seeds some output bits.
    bus.host_we_pins = 1'b1; bus.host_mask = 32'h00FF0000; bus.host_data = 32'hFFFFFFFF;
    step();
    chk("host_pins", bus.fsm_output, 32'h00FF0000);

    // OUT wrapping past pin 31.
    idle();
    bus.out_valid = 1'b1; bus.out_base = 5'd30; bus.out_count = 6'd4; bus.out_data = 32'hF;
    step();
    chk("out_wrap", bus.fsm_output, 32'hC0FF0003);
    chk("out_wrap_drive", bus.fsm_drive, 32'h0);

    // Clear output, then SET with side-set overriding pins 2..3.
    idle();
    bus.host_we_pins = 1'b1; bus.host_mask = 32'hFFFFFFFF; bus.host_data = 32'h0;
    step();
    idle();
    bus.set_valid = 1'b1; bus.set_base = 5'd0; bus.set_count = 3'd5; bus.set_data = 5'h1F;
    bus.sideset_valid = 1'b1; bus.sideset_base = 5'd2; bus.sideset_count = 3'd2; bus.sideset_data = 5'h0;
    step();
    chk("set_sideset", bus.fsm_output, 32'h00000013);
    chk("set_sideset_noconf", {31'b0, bus.write_conflict}, 32'h0);

    // Clear, then OUT and SET together: SET wins low pins, conflict pulses.
    idle();
    bus.host_we_pins = 1'b1; bus.host_mask = 32'hFFFFFFFF; bus.host_data = 32'h0;
    step();
    idle();
    bus.out_valid = 1'b1; bus.out_base = 5'd0; bus.out_count = 6'd8; bus.out_data = 32'hAA;
    bus.set_valid = 1'b1; bus.set_base = 5'd0; bus.set_count = 3'd3; bus.set_data = 5'h5;
    step();
    chk("out_set_overlap", bus.fsm_output, 32'h000000AD);
    chk("conflict_pulse", {31'b0, bus.write_conflict}, 32'h1);
    idle();
    step();
    chk("conflict_clear", {31'b0, bus.write_conflict}, 32'h0);
    chk("out_set_hold", bus.fsm_output, 32'h000000AD);

    // FSM disabled: OUT ignored, host dirs write still lands.
    idle();
    bus.fsm_enable = 1'b0;
    bus.out_valid = 1'b1; bus.out_count = 6'd32; bus.out_data = 32'hFFFFFFFF;
    bus.host_we_dirs = 1'b1; bus.host_mask = 32'h000000FF; bus.host_data = 32'h0000000F;
    step();
    chk("disabled_out", bus.fsm_output, 32'h000000AD);
    chk("disabled_host_dirs", bus.fsm_drive, 32'h0000000F);

    // OUT count clamp to 32 with base 16: full-width rotated write.
    idle();
    bus.host_we_pins = 1'b1; bus.host_mask = 32'hFFFFFFFF; bus.host_data = 32'hFFFFFFFF;
    step();
    idle();
    bus.out_valid = 1'b1; bus.out_base = 5'd16; bus.out_count = 6'd40; bus.out_data = 32'h0000FFFF;
    step();
    chk("out_clamp", bus.fsm_output, 32'hFFFF0000);

    // SET count 7 clamps to 5 pins (28..31, 0) on the drive latch.
    idle();
    bus.host_we_dirs = 1'b1; bus.host_mask = 32'hFFFFFFFF; bus.host_data = 32'hFFFFFFFF;
    step();
    idle();
    bus.set_valid = 1'b1; bus.set_to_dirs = 1'b1; bus.set_base = 5'd28; bus.set_count = 3'd7; bus.set_data = 5'h0;
    step();
    chk("set_clamp", bus.fsm_drive, 32'h0FFFFFFE);

    // OUT to PINS plus side-set to PINDIRS in one cycle.
    idle();
    bus.out_valid = 1'b1; bus.out_base = 5'd4; bus.out_count = 6'd4; bus.out_data = 32'h5;
    bus.sideset_valid = 1'b1; bus.sideset_pindirs = 1'b1; bus.sideset_base = 5'd8;
    bus.sideset_count = 3'd3; bus.sideset_data = 5'h0;
    step();
    chk("split_pins", bus.fsm_output, 32'hFFFF0050);
    chk("split_dirs", bus.fsm_drive, 32'h0FFFF8FE);

    // OUT beats host on pins; side-set beats SET on dirs.
    idle();
    bus.host_we_pins = 1'b1; bus.host_mask = 32'h000000FF; bus.host_data = 32'h0;
    bus.out_valid = 1'b1; bus.out_base = 5'd0; bus.out_count = 6'd4; bus.out_data = 32'hF;
    bus.set_valid = 1'b1; bus.set_to_dirs = 1'b1; bus.set_base = 5'd0; bus.set_count = 3'd5; bus.set_data = 5'h1F;
    bus.sideset_valid = 1'b1; bus.sideset_pindirs = 1'b1; bus.sideset_base = 5'd0;
    bus.sideset_count = 3'd2; bus.sideset_data = 5'h0;
    step();
    chk("prio_pins", bus.fsm_output, 32'hFFFF000F);
    chk("prio_dirs", bus.fsm_drive, 32'h0FFFF8FC);

    // Count zero is a no-op.
    idle();
    bus.out_valid = 1'b1; bus.out_count = 6'd0; bus.out_data = 32'hFFFFFFFF;
    step();
    chk("count_zero", bus.fsm_output, 32'hFFFF000F);

    // Reset asserted alongside an event discards it.
    idle();
    rst = 1'b1;
    bus.out_valid = 1'b1; bus.out_count = 6'd32; bus.out_data = 32'hFFFFFFFF;
    step();
    chk("midrst_out", bus.fsm_output, 32'h0);
    chk("midrst_drive", bus.fsm_drive, 32'h0);
    rst = 1'b0;
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
